conv_host_if: RTL and testbench

Single-clock host-side driver for the convolution CDC subsystem: it buffers one pattern (6 image rows, 6 kernels), transmits it on the `in_valid`/`in_row`/`in_kernel` input stream, then receives the 150-result `out_valid`/`out_data` stream. While receiving, it counts, checksums and optionally checks every result. It sits on the clk1-side top boundary, in place of the pattern generator, for on-chip self-test and board bring-up.

---
 rtl/conv_host_if.sv | 270 +++++++++++++++++++++++++++
 tb/tb_conv_host_if.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_host_if.sv
// conv_host_if: host-side driver for the convolution CDC subsystem.
//
// Buffers one pattern (NUM_ROWS image rows and NUM_ROWS 2x2 kernels) and
// streams it out on in_valid/in_row/in_kernel, one slot per cycle. It then
// collects NUM_OUT results from out_valid/out_data, counting and summing them
// and watching for a gap longer than TIMEOUT cycles between results.
//
// Optional feature macro: CONV_HOST_GOLDEN_EN
//   defined   - a reference model checks every result; mismatch_cnt counts misses
//   undefined - no reference model; mismatch_cnt is tied to 0
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   ld_valid/idx/row/kernel   buffer load port (accepted in IDLE only)
//   ld_ready             high in IDLE
//   start                begin a pattern (accepted in IDLE only)
//   busy                 high in SEND and WAIT
//   done                 one-cycle pulse at pattern end
//   in_valid/row/kernel  stream to the subsystem (registered)
//   out_valid/out_data   result stream from the subsystem
//   res_cnt, res_sum     result count and unsigned sum
//   err_timeout          sticky, gap between results exceeded TIMEOUT
//   err_spurious         sticky, out_valid seen outside WAIT
//   mismatch_cnt         results differing from the golden value (saturating)

module conv_host_if #(
  parameter int unsigned NUM_ROWS = 6,
  parameter int unsigned NUM_OUT  = 150,
  parameter int unsigned TIMEOUT  = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  input  logic [2:0]  ld_idx,
  input  logic [17:0] ld_row,
  input  logic [11:0] ld_kernel,
  output logic        ld_ready,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        in_valid,
  output logic [17:0] in_row,
  output logic [11:0] in_kernel,
  input  logic        out_valid,
  input  logic [7:0]  out_data,
  output logic [7:0]  res_cnt,
  output logic [15:0] res_sum,
  output logic        err_timeout,
  output logic        err_spurious,
  output logic [7:0]  mismatch_cnt
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        slot_q, slot_d;
  logic [2:0]        slot_nxt;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [17:0]       row_q [NUM_ROWS];
  logic [17:0]       row_d [NUM_ROWS];
  logic [11:0]       kernel_q [NUM_ROWS];
  logic [11:0]       kernel_d [NUM_ROWS];
  logic              in_valid_q, in_valid_d;
  logic [17:0]       in_row_q, in_row_d;
  logic [11:0]       in_kernel_q, in_kernel_d;
  logic              done_q, done_d;
  logic [7:0]        res_cnt_q, res_cnt_d;
  logic [15:0]       res_sum_q, res_sum_d;
  logic              err_tmo_q, err_tmo_d;
  logic              err_spur_q, err_spur_d;

  assign slot_nxt = slot_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    tmo_d       = tmo_q;
    row_d       = row_q;
    kernel_d    = kernel_q;
    in_valid_d  = 1'b0;
    in_row_d    = '0;
    in_kernel_d = '0;
    done_d      = 1'b0;
    res_cnt_d   = res_cnt_q;
    res_sum_d   = res_sum_q;
    err_tmo_d   = err_tmo_q;
    err_spur_d  = err_spur_q;

    unique case (state_q)
      StIdle: begin
        if (ld_valid && (32'(ld_idx) < NUM_ROWS)) begin
          row_d[ld_idx]    = ld_row;
          kernel_d[ld_idx] = ld_kernel;
        end
        if (start) begin
          state_d     = StSend;
          slot_d      = 3'd0;
          in_valid_d  = 1'b1;
          // Forward a same-cycle load of slot 0.
          in_row_d    = row_d[0];
          in_kernel_d = kernel_d[0];
          res_cnt_d   = '0;
          res_sum_d   = '0;
          err_tmo_d   = 1'b0;
          err_spur_d  = 1'b0;
        end
      end
      StSend: begin
        if (slot_q == 3'(NUM_ROWS - 1)) begin
          state_d = StWait;
          tmo_d   = '0;
        end else begin
          slot_d      = slot_nxt;
          in_valid_d  = 1'b1;
          in_row_d    = row_q[slot_nxt];
          in_kernel_d = kernel_q[slot_nxt];
        end
      end
      StWait: begin
        if (out_valid) begin
          res_cnt_d = res_cnt_q + 8'd1;
          res_sum_d = res_sum_q + 16'(out_data);
          tmo_d     = '0;
          if (res_cnt_q == 8'(NUM_OUT - 1)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          err_tmo_d = 1'b1;
          state_d   = StDone;
          done_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Results outside WAIT are flagged and dropped; this wins over a start clear.
    if (out_valid && (state_q != StWait)) begin
      err_spur_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      slot_q      <= '0;
      tmo_q       <= '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
        row_q[i]    <= '0;
        kernel_q[i] <= '0;
      end
      in_valid_q  <= 1'b0;
      in_row_q    <= '0;
      in_kernel_q <= '0;
      done_q      <= 1'b0;
      res_cnt_q   <= '0;
      res_sum_q   <= '0;
      err_tmo_q   <= 1'b0;
      err_spur_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      tmo_q       <= tmo_d;
      row_q       <= row_d;
      kernel_q    <= kernel_d;
      in_valid_q  <= in_valid_d;
      in_row_q    <= in_row_d;
      in_kernel_q <= in_kernel_d;
      done_q      <= done_d;
      res_cnt_q   <= res_cnt_d;
      res_sum_q   <= res_sum_d;
      err_tmo_q   <= err_tmo_d;
      err_spur_q  <= err_spur_d;
    end
  end

`ifdef CONV_HOST_GOLDEN_EN
  // Result order: kernel-major, then output row y, then output column x.
  localparam int unsigned OutDim = NUM_ROWS - 1;

  logic [2:0] gx_q, gx_d;
  logic [2:0] gy_q, gy_d;
  logic [2:0] gk_q, gk_d;
  logic [2:0] gy_p1;
  logic [7:0] mism_q, mism_d;
  logic [7:0] golden;
  logic [11:0] kern;
  logic [2:0] p00, p01, p10, p11;
  logic       accept;
  logic       start_acc;

  assign accept    = (state_q == StWait) && out_valid;
  assign start_acc = (state_q == StIdle) && start;
  assign gy_p1     = gy_q + 3'd1;
  assign kern      = kernel_q[gk_q];
  assign p00       = row_q[gy_q][3*gx_q +: 3];
  assign p01       = row_q[gy_q][3*gx_q + 3 +: 3];
  assign p10       = row_q[gy_p1][3*gx_q +: 3];
  assign p11       = row_q[gy_p1][3*gx_q + 3 +: 3];
  assign golden    = 8'(p00) * 8'(kern[2:0]) + 8'(p01) * 8'(kern[5:3])
                   + 8'(p10) * 8'(kern[8:6]) + 8'(p11) * 8'(kern[11:9]);

  always_comb begin
    gx_d   = gx_q;
    gy_d   = gy_q;
    gk_d   = gk_q;
    mism_d = mism_q;
    if (start_acc) begin
      gx_d   = '0;
      gy_d   = '0;
      gk_d   = '0;
      mism_d = '0;
    end else if (accept) begin
      if ((out_data != golden) && (mism_q != 8'hFF)) begin
        mism_d = mism_q + 8'd1;
      end
      if (gx_q == 3'(OutDim - 1)) begin
        gx_d = '0;
        if (gy_q == 3'(OutDim - 1)) begin
          gy_d = '0;
          gk_d = gk_q + 3'd1;
        end else begin
          gy_d = gy_p1;
        end
      end else begin
        gx_d = gx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gx_q   <= '0;
      gy_q   <= '0;
      gk_q   <= '0;
      mism_q <= '0;
    end else begin
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      gk_q   <= gk_d;
      mism_q <= mism_d;
    end
  end

  assign mismatch_cnt = mism_q;
`else
  assign mismatch_cnt = '0;
`endif

  assign ld_ready     = (state_q == StIdle);
  assign busy         = (state_q == StSend) || (state_q == StWait);
  assign done         = done_q;
  assign in_valid     = in_valid_q;
  assign in_row       = in_row_q;
  assign in_kernel    = in_kernel_q;
  assign res_cnt      = res_cnt_q;
  assign res_sum      = res_sum_q;
  assign err_timeout  = err_tmo_q;
  assign err_spurious = err_spur_q;

endmodule

// File: tb/tb_conv_host_if.sv
// Self-checking bench for conv_host_if: a table of full-pattern runs plus
// hand-written reset, idle-spurious and timeout sequences.

module tb_conv_host_if;

  localparam int unsigned TbTimeout = 50;
  localparam int unsigned NumOut    = 150;
`ifdef CONV_HOST_GOLDEN_EN
  localparam bit GoldenEn = 1'b1;
`else
  localparam bit GoldenEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic [2:0]  ld_idx;
  logic [17:0] ld_row;
  logic [11:0] ld_kernel;
  logic        ld_ready;
  logic        start;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic [17:0] in_row;
  logic [11:0] in_kernel;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [7:0]  res_cnt;
  logic [15:0] res_sum;
  logic        err_timeout;
  logic        err_spurious;
  logic [7:0]  mismatch_cnt;

  conv_host_if #(
    .NUM_ROWS (6),
    .NUM_OUT  (NumOut),
    .TIMEOUT  (TbTimeout)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_valid     (ld_valid),
    .ld_idx       (ld_idx),
    .ld_row       (ld_row),
    .ld_kernel    (ld_kernel),
    .ld_ready     (ld_ready),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .in_valid     (in_valid),
    .in_row       (in_row),
    .in_kernel    (in_kernel),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .res_cnt      (res_cnt),
    .res_sum      (res_sum),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious),
    .mismatch_cnt (mismatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Bench-side copy of what the buffers should hold.
  logic [17:0] mrow [6];
  logic [11:0] mker [6];

  typedef struct {
    bit do_load;
    int fill;        // 0: all pixels/kernels 7, 1: row i = i, kernel k0=1
    int n_res;       // results returned before silence
    int bad_idx;     // result returned as golden+1, -1 for none
    int inject_at;   // start+ld_valid pulse in WAIT before this result, -1 none
    bit spur_send;   // out_valid pulse during SEND slot 2
    int exp_cnt;
    int exp_sum;
    int exp_mism;    // expected with the golden model compiled in
    bit exp_tmo;
    bit exp_spur;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] golden(input int n);
    int j, m, x, y, s;
    logic [17:0] r0, r1;
    logic [11:0] k;
    j  = n / 25;
    m  = n % 25;
    y  = m / 5;
    x  = m % 5;
    r0 = mrow[y];
    r1 = mrow[y+1];
    k  = mker[j];
    s  = int'(r0[3*x +: 3]) * int'(k[2:0]) + int'(r0[3*x+3 +: 3]) * int'(k[5:3])
       + int'(r1[3*x +: 3]) * int'(k[8:6]) + int'(r1[3*x+3 +: 3]) * int'(k[11:9]);
    return 8'(s);
  endfunction

  task automatic do_load(input int fill);
    logic [2:0] p;
    for (int i = 0; i < 6; i++) begin
      p = 3'(i);
      if (fill == 0) begin
        mrow[i] = 18'h3FFFF;
        mker[i] = 12'hFFF;
      end else begin
        mrow[i] = {6{p}};
        mker[i] = 12'h001;
      end
      ld_valid  = 1'b1;
      ld_idx    = p;
      ld_row    = mrow[i];
      ld_kernel = mker[i];
      tick();
    end
    // Slots 6 and 7 do not exist and must not alias onto real slots.
    ld_idx = 3'd6; ld_row = 18'h2AAAA; ld_kernel = 12'h555;
    tick();
    ld_idx = 3'd7;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_stream(input bit spur_slot2);
    check("pre_in_valid", in_valid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 6; s++) begin
      check($sformatf("send%0d_in_valid", s), in_valid, 1);
      check($sformatf("send%0d_in_row", s), in_row, mrow[s]);
      check($sformatf("send%0d_in_kernel", s), in_kernel, mker[s]);
      if (spur_slot2 && s == 2) begin
        out_valid = 1'b1;
        out_data  = 8'd200;
      end
      tick();
      out_valid = 1'b0;
    end
    check("post_in_valid", in_valid, 0);
    check("post_in_row", in_row, 0);
    check("post_in_kernel", in_kernel, 0);
    check("wait_busy", busy, 1);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    logic [7:0] d;
    int k;
    if (v.do_load) do_load(v.fill);
    send_stream(v.spur_send);
    for (int n = 0; n < v.n_res; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (n == v.inject_at) begin
        start = 1'b1; ld_valid = 1'b1; ld_idx = 3'd0;
        ld_row = 18'h15555; ld_kernel = 12'hABC;
        tick();
        start = 1'b0; ld_valid = 1'b0;
        check($sformatf("v%0d_inject_busy", vi), busy, 1);
        check($sformatf("v%0d_inject_ld_ready", vi), ld_ready, 0);
      end
      d = golden(n);
      if (n == v.bad_idx) d = d + 8'd1;
      out_valid = 1'b1;
      out_data  = d;
      tick();
      out_valid = 1'b0;
    end
    if (v.n_res < NumOut) begin
      k = 0;
      while (!err_timeout && k < int'(TbTimeout) + 10) begin
        tick();
        k++;
      end
      check($sformatf("v%0d_timeout_cycles", vi), k, TbTimeout);
    end
    check($sformatf("v%0d_done", vi), done, 1);
    check($sformatf("v%0d_res_cnt", vi), res_cnt, v.exp_cnt);
    check($sformatf("v%0d_res_sum", vi), res_sum, v.exp_sum);
    check($sformatf("v%0d_mismatch_cnt", vi), mismatch_cnt, GoldenEn ? v.exp_mism : 0);
    check($sformatf("v%0d_err_timeout", vi), err_timeout, v.exp_tmo);
    check($sformatf("v%0d_err_spurious", vi), err_spurious, v.exp_spur);
    tick();
    check($sformatf("v%0d_done_pulse_end", vi), done, 0);
    check($sformatf("v%0d_back_idle", vi), ld_ready, 1);
    k = 0;
    while (!ld_ready && k < int'(TbTimeout) + 20) begin
      tick();
      k++;
    end
  endtask

  initial begin
    vecs[0] = '{1, 0, 150, -1, -1, 0, 150, 29400, 0, 0, 0};
    vecs[1] = '{1, 1, 150, 37, -1, 0, 150, 301, 1, 0, 0};
    vecs[2] = '{1, 1, 100, -1, -1, 0, 100, 200, 0, 1, 0};
    vecs[3] = '{0, 1, 150, -1, 10, 0, 150, 300, 0, 0, 0};
    vecs[4] = '{0, 1, 150, -1, -1, 1, 150, 300, 0, 0, 1};

    rst_n = 1'b0; ld_valid = 1'b0; ld_idx = '0; ld_row = '0; ld_kernel = '0;
    start = 1'b0; out_valid = 1'b0; out_data = '0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_ld_ready", ld_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_valid", in_valid, 0);
    check("rst_res_cnt", res_cnt, 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_spurious", err_spurious, 0);
    check("rst_mismatch_cnt", mismatch_cnt, 0);

    for (int vi = 0; vi < 5; vi++) begin
      if (vecs[vi].inject_at >= 0) begin
        // Spurious result in IDLE: flagged, dropped, state untouched.
        out_valid = 1'b1;
        out_data  = 8'd99;
        tick();
        out_valid = 1'b0;
        check("idle_spur_flag", err_spurious, 1);
        check("idle_spur_ld_ready", ld_ready, 1);
        check("idle_spur_busy", busy, 0);
        check("idle_spur_res_cnt", res_cnt, 100);
        check("idle_spur_res_sum", res_sum, 200);
      end
      run_vec(vi, vecs[vi]);
    end

    // Reset during SEND slot 3, with a spurious flag already raised.
    do_load(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    out_valid = 1'b1;
    tick();
    out_valid = 1'b0;
    tick();
    check("rsend_slot3_row", in_row, mrow[3]);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rsend_in_valid", in_valid, 0);
    check("rsend_busy", busy, 0);
    check("rsend_ld_ready", ld_ready, 1);
    check("rsend_res_cnt", res_cnt, 0);
    check("rsend_res_sum", res_sum, 0);
    check("rsend_err_spurious", err_spurious, 0);
    check("rsend_in_row", in_row, 0);

    // Buffers are cleared by reset: the next stream is all zero, then it times out.
    for (int i = 0; i < 6; i++) begin
      mrow[i] = '0;
      mker[i] = '0;
    end
    send_stream(1'b0);
    begin
      int k;
      k = 0;
      while (!done && k < int'(TbTimeout) + 10) begin
        tick();
        k++;
      end
      check("rsend_tmo_cycles", k, TbTimeout);
    end
    check("rsend_tmo_done", done, 1);
    check("rsend_tmo_flag", err_timeout, 1);
    check("rsend_tmo_res_cnt", res_cnt, 0);
    tick();
    check("rsend_tmo_idle", ld_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
